// File: rtl/hex7seg_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed hex display driver.
// Segment vectors are {a,b,c,d,e,f,g}, a in the MSB, active-high.
package hex7seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;

  localparam seg_t HEX_SEG [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/decod_hexa2_7seg.sv
// Combinational nibble to 7-segment decoder (active-high segments).
module decod_hexa2_7seg
  import hex7seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/hex7seg_scan_driver.sv
// Time-multiplexed N-digit hex display driver with tear-free valid/ready loading.
// New values wait in a pending slot and reach the display register only at frame boundaries.
module hex7seg_scan_driver
  import hex7seg_pkg::*;
#(
  parameter  int N_DIGITS       = 4,
  parameter  int REFRESH_DIV    = 1000,
  parameter  int ACTIVE_LOW_SEG = 0,
  parameter  int ACTIVE_LOW_AN  = 0,
  localparam int IDXW           = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  blank_lz,
  input  logic                  load_valid,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  load_ready,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic [IDXW-1:0]       digit_idx
);

  localparam int                  PSW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PSW-1:0]      PS_LAST  = PSW'(REFRESH_DIV - 1);
  localparam logic [IDXW-1:0]     IDX_LAST = IDXW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW_AN != 0) ? '1 : '0;
  localparam seg_t                SEG_OFF  = (ACTIVE_LOW_SEG != 0) ? '1 : SEG_BLANK;
  localparam logic                DP_OFF   = (ACTIVE_LOW_SEG != 0);

  logic [PSW-1:0]        presc_q, presc_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic [N_DIGITS-1:0]   dpreg_q, dpreg_d;
  logic [4*N_DIGITS-1:0] pend_q, pend_d;
  logic [N_DIGITS-1:0]   pdp_q, pdp_d;
  logic                  full_q, full_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_upz;
  logic [N_DIGITS-1:0]   upper_zero;
  logic                  cur_blank;
  seg_t                  dec_seg;
  seg_t                  seg_raw;
  logic                  dp_raw;
  logic [N_DIGITS-1:0]   an_raw;

  assign tick     = enable && (presc_q == PS_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Pending slot is exclusive with the boundary transfer: it is only captured while empty
  // and only drained while full, so both can never happen in the same cycle.
  always_comb begin
    pend_d  = pend_q;
    pdp_d   = pdp_q;
    full_d  = full_q;
    disp_d  = disp_q;
    dpreg_d = dpreg_q;
    if (boundary && full_q) begin
      disp_d  = pend_q;
      dpreg_d = pdp_q;
      full_d  = 1'b0;
    end else if (load_valid && !full_q) begin
      pend_d = value;
      pdp_d  = dp_in;
      full_d = 1'b1;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    cur_upz = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      upper_zero[i] = ((disp_q >> (4 * i)) == '0);
    end
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        cur_nib = disp_q[4*i +: 4];
        cur_dp  = dpreg_q[i];
        cur_upz = upper_zero[i];
      end
    end
  end

  assign cur_blank = blank_lz && (idx_q != '0) && cur_upz && !cur_dp;

  decod_hexa2_7seg u_decod (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    seg_raw = SEG_BLANK;
    dp_raw  = 1'b0;
    an_raw  = '0;
    if (enable && !cur_blank) begin
      seg_raw = dec_seg;
      dp_raw  = cur_dp;
      an_raw  = N_DIGITS'(1) << idx_q;
    end
    seg_d = seg_raw ^ SEG_OFF;
    dp_d  = dp_raw ^ DP_OFF;
    an_d  = an_raw ^ AN_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      dpreg_q <= '0;
      pend_q  <= '0;
      pdp_q   <= '0;
      full_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      an_q    <= AN_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      dpreg_q <= dpreg_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      full_q  <= full_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign load_ready = !full_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;

endmodule
